// File: rtl/sensor_request_latch_pkg.sv
// sensor_request_latch_pkg: shared state encodings and default timing constants
package sensor_request_latch_pkg;
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] LATCHED  = 2'd2;
  localparam logic [1:0] HOLDOFF  = 2'd3;
  localparam int DEBOUNCE_DEF = 4;
  localparam int HOLDOFF_DEF  = 8;
  localparam int CNT_W_DEF    = 4;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous active-high reset
module sync_2ff (
  input  logic CLOCK,
  input  logic RESET,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/sensor_request_latch.sv
// sensor_request_latch: debounced sensor request with clear and hold-off; REQ_COUNT_EN adds a saturating capture counter
module sensor_request_latch
  import sensor_request_latch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int HOLDOFF_CYCLES  = HOLDOFF_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       SENSOR,
  input  logic       LATCH_RESET,
  output logic       request,
  output logic       request_pulse
`ifdef REQ_COUNT_EN
  ,
  output logic [7:0] req_count
`endif
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  logic sync;
  logic [1:0] state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic enter_latched;
  sync_2ff u_sync (.CLOCK(CLOCK), .RESET(RESET), .d(SENSOR), .q(sync));
  always_comb begin
    nxt_state = state;
    nxt_cnt = cnt;
    case (state)
      IDLE: if (sync) begin
        nxt_state = DEBOUNCE_CYCLES == 1 ? LATCHED : DEBOUNCE;
        nxt_cnt = DEBOUNCE_CYCLES == 1 ? '0 : ONE;
      end
      DEBOUNCE: begin
        nxt_state = !sync ? IDLE : cnt == DB_LAST ? LATCHED : DEBOUNCE;
        nxt_cnt = !sync || cnt == DB_LAST ? '0 : cnt + ONE;
      end
      LATCHED: if (LATCH_RESET) begin
        nxt_state = HOLDOFF_CYCLES == 0 ? IDLE : HOLDOFF;
        nxt_cnt = '0;
      end
      default: begin
        nxt_state = cnt == HO_LAST ? IDLE : HOLDOFF;
        nxt_cnt = cnt == HO_LAST ? '0 : cnt + ONE;
      end
    endcase
  end
  assign enter_latched = nxt_state == LATCHED && state != LATCHED;
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      request <= 1'b0;
      request_pulse <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      request <= nxt_state == LATCHED;
      request_pulse <= enter_latched;
    end
`ifdef REQ_COUNT_EN
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) req_count <= '0;
    else if (enter_latched && req_count != 8'hff) req_count <= req_count + 8'd1;
`endif
endmodule

// File: tb/tb_sensor_request_latch.sv
// tb_sensor_request_latch: directed checks of capture, glitch reject, clear/hold-off and async reset
module tb_sensor_request_latch;
  import sensor_request_latch_pkg::*;
  logic CLOCK = 1'b0, RESET = 1'b1, SENSOR = 1'b0, LATCH_RESET = 1'b0;
  logic request, request_pulse;
  int n_vec = 0, n_err = 0;
`ifdef REQ_COUNT_EN
  logic [7:0] req_count;
`endif
  sensor_request_latch dut (
    .CLOCK(CLOCK), .RESET(RESET), .SENSOR(SENSOR), .LATCH_RESET(LATCH_RESET),
    .request(request), .request_pulse(request_pulse)
`ifdef REQ_COUNT_EN
    , .req_count(req_count)
`endif
  );
  always #5 CLOCK = ~CLOCK;
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    step(2);
    RESET = 1'b0;
    chk("rst_req", request, 0);
    chk("rst_pulse", request_pulse, 0);
    chk("rst_state", dut.state, IDLE);
    SENSOR = 1'b1;
    step(5);
    chk("deb_e5_req", request, 0);
    step(1);
    chk("deb_e6_req", request, 1);
    chk("deb_e6_pulse", request_pulse, 1);
    step(1);
    chk("deb_e7_pulse", request_pulse, 0);
    chk("deb_e7_req", request, 1);
    LATCH_RESET = 1'b1;
    step(1);
    LATCH_RESET = 1'b0;
    chk("clr_t_req", request, 0);
    chk("clr_t_state", dut.state, HOLDOFF);
    step(7);
    chk("ho_t7_state", dut.state, HOLDOFF);
    step(1);
    chk("ho_t8_state", dut.state, IDLE);
    step(3);
    chk("rearm_t11_req", request, 0);
    step(1);
    chk("rearm_t12_req", request, 1);
    chk("rearm_t12_pulse", request_pulse, 1);
    LATCH_RESET = 1'b1;
    SENSOR = 1'b0;
    step(1);
    LATCH_RESET = 1'b0;
    SENSOR = 1'b1;
    step(2);
    SENSOR = 1'b0;
    step(5);
    chk("ho_tog_state", dut.state, HOLDOFF);
    step(1);
    chk("ho_tog_idle", dut.state, IDLE);
    step(6);
    chk("ho_tog_req", request, 0);
    chk("ho_tog_state2", dut.state, IDLE);
    SENSOR = 1'b1;
    step(3);
    SENSOR = 1'b0;
    step(2);
    chk("gl_e5_state", dut.state, DEBOUNCE);
    step(1);
    chk("gl_e6_state", dut.state, IDLE);
    chk("gl_e6_req", request, 0);
    step(4);
    chk("gl_late_req", request, 0);
    SENSOR = 1'b1;
    step(3);
    chk("lrdb_state", dut.state, DEBOUNCE);
    LATCH_RESET = 1'b1;
    step(1);
    LATCH_RESET = 1'b0;
    step(1);
    chk("lrdb_e5_req", request, 0);
    step(1);
    chk("lrdb_e6_req", request, 1);
    #2 RESET = 1'b1;
    #1;
    chk("arst_req", request, 0);
    chk("arst_pulse", request_pulse, 0);
    chk("arst_state", dut.state, IDLE);
    SENSOR = 1'b0;
    step(1);
    RESET = 1'b0;
    step(10);
    chk("post_rst_req", request, 0);
    chk("post_rst_state", dut.state, IDLE);
`ifdef REQ_COUNT_EN
    chk("cnt_rst", req_count, 0);
    SENSOR = 1'b1;
    LATCH_RESET = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      for (int w = 0; w < 20 && !request_pulse; w++) step(1);
      if (!request_pulse) begin
        chk("cnt_timeout", request_pulse, 1);
        break;
      end
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 260)
        chk($sformatf("cnt_%0d", i), req_count, (i > 255) ? 255 : i);
      step(1);
    end
    LATCH_RESET = 1'b0;
    SENSOR = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
